// File: rtl/neosd_pkg.sv
// Shared NEOSD command-path types and constants: response modes, CRC7 polynomial,
// error codes and response word counts.
package neosd_pkg;

  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_SHORT = 2'd1,
    RESP_LONG  = 2'd2
  } resp_mode_e;

  localparam logic [1:0] RESP_RSVD = 2'd3;

  // x^7 + x^3 + 1 with the x^7 term implicit
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_RMODE   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [2:0] RESP_WORDS_SHORT = 3'd2;
  localparam logic [2:0] RESP_WORDS_LONG  = 3'd5;

  localparam int unsigned RESP_BUF_WORDS = 5;
  localparam int unsigned CMD_FRAME_BITS = 40;

  typedef enum logic [2:0] {
    StIdle,
    StCrc,
    StLoad,
    StStart,
    StWait,
    StAck,
    StDrain,
    StDone
  } cmd_seq_state_e;

  function automatic logic [2:0] resp_words(input logic [1:0] rmode);
    logic [2:0] n;
    case (rmode)
      RESP_SHORT: n = RESP_WORDS_SHORT;
      RESP_LONG:  n = RESP_WORDS_LONG;
      default:    n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/neosd_cmd_seq_if.sv
// Requester-side interface of the NEOSD command sequencer: request handshake,
// completion status and response buffer read port.
interface neosd_cmd_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_idx;
  logic [31:0] req_arg;
  logic [1:0]  req_rmode;
  logic        done;
  logic [1:0]  err;
  logic [2:0]  resp_cnt;
  logic [2:0]  resp_sel;
  logic [31:0] resp_word;

  modport master (
    output req_valid, req_idx, req_arg, req_rmode, resp_sel,
    input  req_ready, done, err, resp_cnt, resp_word
  );

  modport slave (
    input  req_valid, req_idx, req_arg, req_rmode, resp_sel,
    output req_ready, done, err, resp_cnt, resp_word
  );
endinterface

// File: rtl/neosd_crc7.sv
// Bit-serial CRC7 (x^7+x^3+1, MSB first) with synchronous clear; shared by the
// command and data paths.
module neosd_crc7
  import neosd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;
  logic       fb;

  assign fb    = bit_i ^ crc_q[6];
  assign crc_o = crc_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      crc_q <= '0;
    end else if (clr_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/neosd_cmd_seq.sv
// NEOSD command sequencer: CRC7 generation, command register load, start/ack
// handshakes with neosd_cmd_fsm and response buffering. NEOSD_CMD_TIMEOUT_EN adds a WAIT timeout.
module neosd_cmd_seq
  import neosd_pkg::*;
#(
  parameter int unsigned TIMEOUT_STRB = 64
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           clkstrb_i,
  neosd_cmd_seq_if.slave req_if,
  output logic [5:0]     cmd_idx_o,
  output logic [31:0]    cmd_arg_o,
  output logic [6:0]     cmd_crc_o,
  output logic           cmd_idx_load_o,
  output logic [3:0]     cmd_arg_load_o,
  output logic           cmd_crc_load_o,
  output logic           ctrl_start_o,
  output logic           ctrl_resp_ack_o,
  output logic [1:0]     ctrl_rmode_o,
  input  logic           status_idle_i,
  input  logic           status_resp_i,
  input  logic [31:0]    resp_data_i
);

  if (TIMEOUT_STRB == 0) begin : g_bad_timeout
    $error("TIMEOUT_STRB must be nonzero");
  end

  cmd_seq_state_e state_q;
  logic [5:0]     idx_q;
  logic [31:0]    arg_q;
  logic [1:0]     rmode_q;
  logic [1:0]     err_q;
  logic [2:0]     resp_cnt_q;
  logic [5:0]     bit_cnt_q;
  logic [31:0]    rbuf_q [RESP_BUF_WORDS];

`ifdef NEOSD_CMD_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_STRB + 1);
  logic [TmoW-1:0] tmo_q;
`endif

  logic                      accept;
  logic [CMD_FRAME_BITS-1:0] frame;
  logic                      crc_bit;

  assign req_if.req_ready = (state_q == StIdle) && status_idle_i;
  assign accept           = req_if.req_valid && req_if.req_ready;

  // Start bit 0, transmission bit 1, then index and argument, sent MSB first
  assign frame   = {2'b01, idx_q, arg_q};
  assign crc_bit = frame[6'd39 - bit_cnt_q];

  neosd_crc7 u_crc7 (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (accept),
    .en_i   (state_q == StCrc),
    .bit_i  (crc_bit),
    .crc_o  (cmd_crc_o)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      arg_q      <= '0;
      rmode_q    <= '0;
      err_q      <= ERR_OK;
      resp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      for (int i = 0; i < int'(RESP_BUF_WORDS); i++) rbuf_q[i] <= '0;
`ifdef NEOSD_CMD_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            idx_q      <= req_if.req_idx;
            arg_q      <= req_if.req_arg;
            rmode_q    <= req_if.req_rmode;
            resp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            for (int i = 0; i < int'(RESP_BUF_WORDS); i++) rbuf_q[i] <= '0;
`ifdef NEOSD_CMD_TIMEOUT_EN
            tmo_q      <= '0;
`endif
            // The command FSM would never finish a reserved mode, so never start it
            if (req_if.req_rmode == RESP_RSVD) begin
              err_q   <= ERR_RMODE;
              state_q <= StDone;
            end else begin
              err_q   <= ERR_OK;
              state_q <= StCrc;
            end
          end
        end
        StCrc: begin
          bit_cnt_q <= bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'(CMD_FRAME_BITS - 1)) state_q <= StLoad;
        end
        StLoad: begin
          // The register only takes the loads on a strobe cycle
          if (clkstrb_i) state_q <= StStart;
        end
        StStart: begin
          if (!status_idle_i) state_q <= (rmode_q == RESP_NONE) ? StDrain : StWait;
        end
        StWait: begin
          if (status_resp_i) begin
            if (resp_cnt_q < 3'(RESP_BUF_WORDS)) rbuf_q[resp_cnt_q] <= resp_data_i;
            resp_cnt_q <= resp_cnt_q + 3'd1;
            state_q    <= StAck;
`ifdef NEOSD_CMD_TIMEOUT_EN
            tmo_q      <= '0;
          end else if (clkstrb_i) begin
            if (tmo_q == TmoW'(TIMEOUT_STRB - 1)) begin
              err_q   <= ERR_TIMEOUT;
              state_q <= StDone;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
`endif
          end
        end
        StAck: begin
          if (!status_resp_i) begin
            state_q <= (resp_cnt_q >= resp_words(rmode_q)) ? StDrain : StWait;
          end
        end
        StDrain: begin
          if (status_idle_i) state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    req_if.resp_word = '0;
    if (req_if.resp_sel < 3'(RESP_BUF_WORDS)) req_if.resp_word = rbuf_q[req_if.resp_sel];
  end

  assign req_if.done     = (state_q == StDone);
  assign req_if.err      = err_q;
  assign req_if.resp_cnt = resp_cnt_q;

  assign cmd_idx_o       = idx_q;
  assign cmd_arg_o       = arg_q;
  assign cmd_idx_load_o  = (state_q == StLoad);
  assign cmd_arg_load_o  = {4{state_q == StLoad}};
  assign cmd_crc_load_o  = (state_q == StLoad);
  assign ctrl_start_o    = (state_q == StStart);
  assign ctrl_resp_ack_o = (state_q == StAck);
  assign ctrl_rmode_o    = rmode_q;

endmodule

// File: tb/tb_neosd_cmd_seq.sv
// Self-checking bench for neosd_cmd_seq: a behavioural command-FSM stand-in answers start/ack,
// a vector table drives commands and a scoreboard checks each completion.
module tb_neosd_cmd_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clkstrb = 1'b0;
  logic        status_idle = 1'b1;
  logic        status_resp = 1'b0;
  logic [31:0] resp_data = '0;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic        cmd_idx_load;
  logic [3:0]  cmd_arg_load;
  logic        cmd_crc_load;
  logic        ctrl_start;
  logic        ctrl_resp_ack;
  logic [1:0]  ctrl_rmode;

  neosd_cmd_seq_if rif ();

  neosd_cmd_seq #(.TIMEOUT_STRB(64)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .clkstrb_i       (clkstrb),
    .req_if          (rif),
    .cmd_idx_o       (cmd_idx),
    .cmd_arg_o       (cmd_arg),
    .cmd_crc_o       (cmd_crc),
    .cmd_idx_load_o  (cmd_idx_load),
    .cmd_arg_load_o  (cmd_arg_load),
    .cmd_crc_load_o  (cmd_crc_load),
    .ctrl_start_o    (ctrl_start),
    .ctrl_resp_ack_o (ctrl_resp_ack),
    .ctrl_rmode_o    (ctrl_rmode),
    .status_idle_i   (status_idle),
    .status_resp_i   (status_resp),
    .resp_data_i     (resp_data)
  );

  always #5 clk = ~clk;

  // SD bit strobe: one clk cycle high out of every four
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #3 clkstrb = 1'b1;
      @(posedge clk);
      #3 clkstrb = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  // Event monitor, sampled on the falling edge
  int   start_rise = 0, start_cyc = 0, ack_rise = 0, load_strb = 0;
  logic start_prev = 1'b0, ack_prev = 1'b0;
  always @(negedge clk) begin
    if (ctrl_start && !start_prev) start_rise <= start_rise + 1;
    if (ctrl_start) start_cyc <= start_cyc + 1;
    if (ctrl_resp_ack && !ack_prev) ack_rise <= ack_rise + 1;
    if (cmd_arg_load == 4'hF && clkstrb) load_strb <= load_strb + 1;
    start_prev <= ctrl_start;
    ack_prev   <= ctrl_resp_ack;
  end

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [1:0]  rmode;
    int          nwords;
    logic [31:0] words [5];
    logic [6:0]  crc;
  } vec_t;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic [1:0]  err;
    logic [2:0]  cnt;
    logic [31:0] words [5];
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   checks = 0;
  int   passed = 0;
  int   cur = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL vec%0d %s: got 0x%0h want 0x%0h", cur, name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference CRC7 by polynomial long division of the 40-bit frame
  function automatic logic [6:0] crc7_ref(input logic [5:0] idx, input logic [31:0] arg);
    logic [46:0] r;
    r = {2'b01, idx, arg, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic vec_t mk(input logic [5:0] idx, input logic [31:0] arg,
                              input logic [1:0] rm, input logic [6:0] crc,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [31:0] w4);
    vec_t v;
    v.idx = idx; v.arg = arg; v.rmode = rm; v.crc = crc;
    v.nwords = (rm == 2'd1) ? 2 : (rm == 2'd2) ? 5 : 0;
    v.words[0] = w0; v.words[1] = w1; v.words[2] = w2; v.words[3] = w3; v.words[4] = w4;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   lat, s0, sc0, a0, l0;
    bit   ok, hs_ok;
    e.idx = v.idx; e.arg = v.arg; e.crc = v.crc;
    e.err = (v.rmode == 2'd3) ? 2'd1 : 2'd0;
    e.cnt = 3'(v.nwords);
    for (int i = 0; i < 5; i++) e.words[i] = (i < v.nwords) ? v.words[i] : 32'h0;
    sb.push_back(e);
    s0 = start_rise; sc0 = start_cyc; a0 = ack_rise; l0 = load_strb;

    rif.req_idx = v.idx; rif.req_arg = v.arg; rif.req_rmode = v.rmode;
    rif.req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (rif.req_ready) ok = 1'b1;
      step();
    end
    rif.req_valid = 1'b0;
    chk("accept", 32'(ok), 1);

    if (v.rmode == 2'd3) begin
      chk("rm3_done_next_cycle", 32'(rif.done), 1);
      step();
      chk("rm3_done_one_cycle", 32'(rif.done), 0);
      chk("rm3_no_start", 32'(start_rise - s0), 0);
    end else begin
      lat = 0; ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
        step();
        lat++;
        if (cmd_idx_load) ok = 1'b1;
      end
      // Load strobes appear in the 41st cycle counting the accept cycle
      chk("load_latency", 32'(lat), 40);
      for (int i = 0; i < 200 && !ctrl_start; i++) step();
      chk("start_seen", 32'(ctrl_start), 1);
      repeat (8) step();
      status_idle = 1'b0;
      hs_ok = 1'b1;
      for (int w = 0; w < v.nwords; w++) begin
        repeat (3) step();
        status_resp = 1'b1;
        resp_data = v.words[w];
        for (int i = 0; i < 100 && !ctrl_resp_ack; i++) step();
        if (!ctrl_resp_ack) hs_ok = 1'b0;
        repeat (5) step();
        status_resp = 1'b0;
        resp_data = $urandom;
        for (int i = 0; i < 100 && ctrl_resp_ack; i++) step();
        if (ctrl_resp_ack) hs_ok = 1'b0;
      end
      chk("ack_handshake", 32'(hs_ok), 1);
      repeat (4) step();
      status_idle = 1'b1;
      for (int i = 0; i < 100 && !rif.done; i++) step();
      chk("done_seen", 32'(rif.done), 1);
      chk("start_count", 32'(start_rise - s0), 1);
      chk("start_is_level", 32'((start_cyc - sc0) >= 2), 1);
      chk("arg_load_strobe_cycles", 32'(load_strb - l0), 1);
    end

    e = sb.pop_front();
    chk("err", 32'(rif.err), 32'(e.err));
    chk("resp_cnt", 32'(rif.resp_cnt), 32'(e.cnt));
    chk("ack_count", 32'(ack_rise - a0), 32'(e.cnt));
    if (v.rmode != 2'd3) begin
      chk("cmd_crc", 32'(cmd_crc), 32'(e.crc));
      chk("cmd_idx", 32'(cmd_idx), 32'(e.idx));
      chk("cmd_arg", cmd_arg, e.arg);
    end
    for (int i = 0; i < 5; i++) begin
      rif.resp_sel = 3'(i);
      #1;
      chk($sformatf("word%0d", i), rif.resp_word, e.words[i]);
    end
    rif.resp_sel = 3'd7;
    #1;
    chk("word7_empty", rif.resp_word, 32'h0);
    step();
  endtask

  initial begin
    rif.req_valid = 1'b0; rif.req_idx = '0; rif.req_arg = '0; rif.req_rmode = '0;
    rif.resp_sel = '0;

    vecs[0] = mk(6'd0,  32'h0,     2'd0, 7'h4A, 0, 0, 0, 0, 0);
    vecs[1] = mk(6'd8,  32'h1AA,   2'd1, 7'h43, 32'h0000_0008, 32'h0000_01AA, 0, 0, 0);
    vecs[2] = mk(6'd5,  32'hDEAD,  2'd3, 7'h00, 0, 0, 0, 0, 0);
    vecs[3] = mk(6'd17, 32'h0,     2'd1, 7'h2A, 32'h0000_0011, 32'h0000_0900, 0, 0, 0);
    vecs[4] = mk(6'd2,  32'h0,     2'd2, crc7_ref(6'd2, 32'h0), 32'h0000_003F,
                 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C, 32'h4B5A_6978);
    vecs[5] = mk(6'd55, 32'h0,     2'd1, crc7_ref(6'd55, 32'h0), 32'h0000_0037,
                 32'hCAFE_0120, 0, 0, 0);

    // Reset state
    repeat (3) step();
    chk("rst_done", 32'(rif.done), 0);
    chk("rst_err", 32'(rif.err), 0);
    chk("rst_crc", 32'(cmd_crc), 0);
    chk("rst_start", 32'(ctrl_start), 0);
    chk("rst_ready_follows_idle", 32'(rif.req_ready), 1);
    rstn = 1'b1;
    repeat (2) step();

    for (int k = 0; k < 6; k++) begin
      cur = k;
      run_vec(vecs[k]);
    end

    // Reset in the middle of the CRC phase
    cur = 6;
    rif.req_idx = 6'd8; rif.req_arg = 32'h1AA; rif.req_rmode = 2'd1;
    rif.req_valid = 1'b1;
    step();
    rif.req_valid = 1'b0;
    repeat (10) step();
    chk("pre_reset_rmode", 32'(ctrl_rmode), 1);
    chk("pre_reset_idx", 32'(cmd_idx), 8);
    rstn = 1'b0;
    #1;
    chk("mid_rst_rmode", 32'(ctrl_rmode), 0);
    chk("mid_rst_idx", 32'(cmd_idx), 0);
    chk("mid_rst_arg", cmd_arg, 0);
    chk("mid_rst_crc", 32'(cmd_crc), 0);
    chk("mid_rst_loads", {29'h0, cmd_idx_load, cmd_crc_load, |cmd_arg_load}, 0);
    chk("mid_rst_cnt", 32'(rif.resp_cnt), 0);
    chk("mid_rst_ready", 32'(rif.req_ready), 1);
    repeat (2) step();
    rstn = 1'b1;
    repeat (45) step();
    chk("post_rst_no_load", 32'(cmd_idx_load), 0);
    chk("post_rst_ready", 32'(rif.req_ready), 1);

`ifdef NEOSD_CMD_TIMEOUT_EN
    cur = 7;
    rif.req_idx = 6'd8; rif.req_arg = 32'h1AA; rif.req_rmode = 2'd1;
    rif.req_valid = 1'b1;
    step();
    rif.req_valid = 1'b0;
    for (int i = 0; i < 200 && !ctrl_start; i++) step();
    chk("tmo_start_seen", 32'(ctrl_start), 1);
    repeat (2) step();
    status_idle = 1'b0;
    for (int i = 0; i < 400 && !rif.done; i++) step();
    chk("tmo_done_seen", 32'(rif.done), 1);
    chk("tmo_err", 32'(rif.err), 2);
    step();
    chk("tmo_ready_held_off", 32'(rif.req_ready), 0);
    status_idle = 1'b1;
    step();
    chk("tmo_ready_after_idle", 32'(rif.req_ready), 1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/neosd_cmd_seq.md
# neosd_cmd_seq

Command sequencer for the NEOSD command path. It accepts one SD command descriptor from a requester, generates its CRC7, loads the command shift register, and starts the command FSM. It then drains each 32-bit response word into a local buffer, acknowledging the FSM word by word, and reports completion or error. It sits between the register/bus layer and `neosd_cmd_fsm`, and is the only driver of that FSM's load, start and ack inputs.

## Interface
- `TIMEOUT_STRB`, default 64: clkstrb_i pulses allowed in response wait before timeout (see Configuration).
- `clk_i` in 1: system clock, the one clock.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `clkstrb_i` in 1: SD bit strobe, the same strobe the command FSM uses.
- `req_valid_i` in 1, `req_ready_o` out 1: request handshake; a request is accepted on the cycle both are high.
- `req_idx_i` in 6, `req_arg_i` in 32, `req_rmode_i` in 2: command index, argument, response mode (0 none, 1 short, 2 long, 3 reserved).
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 2: error code, held until the next accept (0 ok, 1 reserved rmode, 2 timeout).
- `resp_cnt_o` out 3: number of response words captured.
- `resp_sel_i` in 3, `resp_word_o` out 32: combinational read of buffer word `resp_sel_i`; word 0 is the first word received.
- `cmd_idx_o` 6, `cmd_arg_o` 32, `cmd_crc_o` 7 out: parallel data to the command FSM.
- `cmd_idx_load_o` 1, `cmd_arg_load_o` 4, `cmd_crc_load_o` 1 out: load strobes.
- `ctrl_start_o`, `ctrl_resp_ack_o` out 1; `ctrl_rmode_o` out 2.
- `status_idle_i`, `status_resp_i` in 1; `resp_data_i` in 32: status and data from the command FSM.

## Operation
- States: IDLE, CRC, LOAD, START, WAIT, ACK, DRAIN, DONE.
- **IDLE**
  - `req_ready_o = (state==IDLE) && status_idle_i`.
  - On accept: latch idx, arg and rmode; clear the buffer to 0, `resp_cnt_o` and `err_o`.
  - If rmode is 3: set `err_o=1` and go to DONE. No start is issued, because the FSM would hang on rmode 3.
  - Otherwise go to CRC.
- **CRC**
  - Bit-serial CRC7, polynomial x^7+x^3+1, initial value 0.
  - Input is the 40 bits {2'b01, idx, arg}, MSB first, one bit per clk_i cycle (not per strobe), for exactly 40 cycles.
  - Then go to LOAD.
- **LOAD**
  - One cycle with all load strobes high (`cmd_arg_load_o=4'hF`). Data outputs are stable from LOAD onward.
  - Because the loads are gated by clkstrb_i in the register, LOAD holds until a cycle with clkstrb_i high, then goes to START.
- **START**
  - `ctrl_start_o` is high while in START.
  - Leave START when `status_idle_i` reads 0.
  - Next state: rmode 0 goes to DRAIN; otherwise WAIT.
- **WAIT**
  - When `status_resp_i` is 1: write `resp_data_i` to `buf[resp_cnt]`, increment `resp_cnt`, go to ACK.
- **ACK**
  - `ctrl_resp_ack_o` is high while in ACK; hold until `status_resp_i` reads 0.
  - Then go to DRAIN if `resp_cnt` has reached the expected word count (short 2, long 5); otherwise WAIT.
- **DRAIN**: wait for `status_idle_i=1`, then go to DONE.
- **DONE**: `done_o` high for one cycle, then go to IDLE.
- `ctrl_rmode_o` is the latched rmode throughout.
- Buffer contents and `err_o` stay stable after DONE until the next accept.
- `req_valid_i` while not ready is ignored; inputs are not sampled.

## Timing
- Reset value of every output and every register is 0.
  - `req_ready_o` follows `status_idle_i` once the block is in IDLE.
- Accept to first load strobe: 41 clk_i cycles minimum (40 CRC cycles + 1), plus the wait for clkstrb_i.
- Start and ack are level handshakes, held across multiple strobes until the FSM status changes. They are never single-cycle pulses.
- Capture in WAIT happens on the first cycle `status_resp_i` is high. `resp_data_i` is stable while `status_resp_i` is high.
- Word order: short response gives 2 words (word 0 holds 16 valid LSBs); long response gives 5 words (word 0 holds 8 valid LSBs).
- Reset asserted mid-operation: everything returns to 0 asynchronously, and the command FSM is reset by the same `rstn_i`.

## Configuration
- `NEOSD_CMD_TIMEOUT_EN` defined:
  - In WAIT, a counter increments on each clkstrb_i and clears on each capture.
  - When it reaches `TIMEOUT_STRB`: set `err_o=2` and go to DONE.
  - The next request is held off by `req_ready_o` until the FSM returns to idle.
- Not defined: no counter, and WAIT waits indefinitely. `TIMEOUT_STRB` is unused.

## Structure
- `neosd_pkg` holds:
  - the `RESP_MODE` enum (`RESP_NONE`, `RESP_SHORT`, `RESP_LONG`), shared with the command FSM;
  - `CRC7_POLY = 7'h09`;
  - the error-code constants;
  - `RESP_WORDS_SHORT = 2` and `RESP_WORDS_LONG = 5`.
- Sub-module `neosd_crc7`: serial CRC7 with clear, enable and data-bit inputs and a 7-bit output. It is reused later by the data path.

## Test plan
- CMD0, arg 0, rmode 0 -> `cmd_crc_o=7'h4A`; one start handshake, no acks; `done_o` pulses with `err_o=0` and `resp_cnt_o=0`.
- CMD8, arg 0x1AA, rmode 1; card answers 0x08_000001AA_xx -> `cmd_crc_o=7'h43`; two acks; word1 = 0x000001AA; `resp_cnt_o=2`.
- CMD17, arg 0, rmode 1 -> `cmd_crc_o=7'h2A`; `cmd_arg_load_o=4'hF` for exactly one clkstrb cycle.
- CMD2, rmode 2, 136-bit response -> exactly 5 acks; `resp_cnt_o=5`; buffer words match the driven pattern.
- rmode 3 -> `ctrl_start_o` never asserted; `done_o` pulses with `err_o=1` one cycle after the state leaves IDLE.
- With `NEOSD_CMD_TIMEOUT_EN`, rmode 1, `sd_cmd` held high -> `err_o=2` after 64 strobes in WAIT. Reset pulse mid-CRC -> all outputs 0 and `req_ready_o=1`.
